shift_pipe_unit: RTL

- Two-stage pipelined shift execution unit for the CPU ALU path.
- Accepts operand, amount and shift opcode over a valid/ready handshake.
- Drives the 32-bit logarithmic right-shift barrel: left shifts by bit reversal around it; arithmetic fill and rotate by masking.
- Result and tag are registered to a downstream consumer (writeback/bypass) with backpressure and flush.

---
 rtl/shift_pipe_unit.sv | 116 +++++++++++
 1 files changed

// File: rtl/shift_pipe_unit.sv
// Two-stage pipelined shift unit: SLL/SRL/SRA/ROR on 32-bit operands.
// It uses one logarithmic right-shift barrel; left shifts are done by reversing the bits around it.
module shift_pipe_unit #(
  parameter int unsigned TAG_W = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic [4:0]        in_amt,
  input  logic [1:0]        in_op,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned AMT_W  = 5;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  function automatic logic [DATA_W-1:0] bitrev(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = v[DATA_W-1-i];
    return r;
  endfunction

  logic              s1_valid;
  logic [DATA_W-1:0] s1_opnd;
  logic [AMT_W-1:0]  s1_amt;
  op_e               s1_op;
  logic [TAG_W-1:0]  s1_tag;
  logic              s1_sign;

  logic              advance_c;
  logic              accept_c;
  logic [DATA_W-1:0] b1_c, b2_c, b3_c, b4_c, shr_c;
  logic [DATA_W-1:0] fill_c;
  logic [AMT_W-1:0]  rot_amt_c;
  logic [DATA_W-1:0] result_c;

  assign advance_c = !out_valid || out_ready;
  assign in_ready  = !flush && (!s1_valid || advance_c);
  assign accept_c  = in_valid && in_ready;

  // Stage 1: capture the request; SLL operands are pre-reversed for the right-shift barrel.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_opnd  <= '0;
      s1_amt   <= '0;
      s1_op    <= OP_SLL;
      s1_tag   <= '0;
      s1_sign  <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (accept_c) begin
      s1_valid <= 1'b1;
      s1_opnd  <= (op_e'(in_op) == OP_SLL) ? bitrev(in_data) : in_data;
      s1_amt   <= in_amt;
      s1_op    <= op_e'(in_op);
      s1_tag   <= in_tag;
      s1_sign  <= in_data[DATA_W-1];
    end else if (advance_c) begin
      s1_valid <= 1'b0;
    end
  end

  // Logarithmic logical right-shift barrel.
  assign b1_c  = s1_amt[0] ? {1'b0,  s1_opnd[DATA_W-1:1]}  : s1_opnd;
  assign b2_c  = s1_amt[1] ? {2'b0,  b1_c[DATA_W-1:2]}     : b1_c;
  assign b3_c  = s1_amt[2] ? {4'b0,  b2_c[DATA_W-1:4]}     : b2_c;
  assign b4_c  = s1_amt[3] ? {8'b0,  b3_c[DATA_W-1:8]}     : b3_c;
  assign shr_c = s1_amt[4] ? {16'b0, b4_c[DATA_W-1:16]}    : b4_c;

  assign fill_c    = ~({DATA_W{1'b1}} >> s1_amt);
  assign rot_amt_c = AMT_W'(AMT_W'(0) - s1_amt);

  always_comb begin
    result_c = shr_c;
    unique case (s1_op)
      OP_SLL: result_c = bitrev(shr_c);
      OP_SRL: result_c = shr_c;
      OP_SRA: result_c = shr_c | (s1_sign ? fill_c : '0);
      OP_ROR: result_c = (s1_amt == '0) ? s1_opnd : (shr_c | (s1_opnd << rot_amt_c));
      default: result_c = shr_c;
    endcase
  end

  // Stage 2: the output register holds its value while downstream stalls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (advance_c) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= result_c;
        out_tag  <= s1_tag;
      end
    end
  end

endmodule
